sobel_out_packer: RTL
=====================

Name: sobel_out_packer

Overview:
- Receive-side endpoint for the 8-bit edge-map stream leaving the Sobel pipeline (valid_s / ready_s / data_s_sobel).
- Accepts pixels under valid/ready handshake, tracks raster position within an IMAGE_WIDTH x IMAGE_HEIGHT frame, and packs 4 pixels per 32-bit word.
- Presents words downstream (frame writer / DMA) on a valid/ready interface with end-of-line and end-of-frame markers.
- Propagates downstream backpressure upstream through ready_s.

Parameters:
IMAGE_WIDTH, 1920, pixels per line; must be a multiple of 4
IMAGE_HEIGHT, 1080, lines per frame
FRAME_CNT_W, 16, width of the frame counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
valid_s  input  1  upstream pixel valid
ready_s  output  1  pixel accept; transfer occurs when valid_s && ready_s
data_s_sobel  input  8  edge pixel (0x00 or 0xFF from threshold stage; any value passed through)
m_valid  output  1  packed word valid
m_ready  input  1  downstream accept; transfer occurs when m_valid && m_ready
m_data  output  32  packed word; pixel 0 of the group in [7:0], pixel 3 in [31:24]
m_sof  output  1  word holds pixel (x=0, y=0)
m_eol  output  1  word holds pixel x=IMAGE_WIDTH-1
m_eof  output  1  word holds the last pixel of the frame (implies m_eol)
frame_cnt  output  FRAME_CNT_W  number of completed frames, wraps modulo 2^FRAME_CNT_W

Behaviour:
- Reset (synchronous, rst=1 at rising edge), next-cycle values:
  - m_valid=0; m_data=0; m_sof/m_eol/m_eof=0; frame_cnt=0.
  - Pack lane index=0; x=0; y=0; partial word discarded.
  - ready_s is 1 after reset.
- Reset mid-frame: any in-flight output word is dropped (m_valid=0), counters restart at (0,0), and the next accepted pixel is the first pixel of a new frame.
- Pack register: lane index k in 0..3 (2-bit counter).
  - Each accepted pixel writes lane k, then k increments.
  - On k=3 the completed word (the 3 stored lanes + the current pixel) loads into the output register with flags; k wraps to 0.
- Output register, single entry:
  - m_valid sets on a load and clears on an m_ready handshake with no simultaneous load.
  - A simultaneous drain and load keeps m_valid=1 with the new word.
  - m_data and flags hold stable while m_valid && !m_ready.
- Latency: 4th pixel accepted at edge N → m_valid=1 with that word after edge N (visible in cycle N+1).
- ready_s = !(k==3 && m_valid && !m_ready). Combinational from m_ready, with no combinational path from valid_s. Lanes 0–2 always accept; lane 3 stalls only while the output register is occupied and not draining.
- Raster counters advance per accepted pixel:
  - x wraps IMAGE_WIDTH-1 → 0 and increments y.
  - y wraps IMAGE_HEIGHT-1 → 0 and increments frame_cnt in the same cycle.
- Flags are captured into the output register with the word:
  - m_sof: word's first pixel at (0,0).
  - m_eol: word's last pixel at x=IMAGE_WIDTH-1.
  - m_eof: last pixel at (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
- frame_cnt increments when the final pixel of the frame is accepted, not when the eof word drains. It wraps 2^FRAME_CNT_W-1 → 0.
- Idle valid_s gaps of any length leave all state unchanged; no timeout.
- Data outside valid_s is ignored; m_data outside m_valid is don't-care but must not be X after reset.

Test Plan:
- Reset, then 4 pixels 0x11,0x22,0x33,0x44 on consecutive cycles, m_ready=1 → one word 0x44332211 with m_valid for exactly 1 cycle, one cycle after 4th accept; m_sof=1, m_eol=0.
- IMAGE_WIDTH=8, IMAGE_HEIGHT=2, 16 pixels 0..15, random valid_s gaps, m_ready=1:
  - words 0x03020100 (sof), 0x07060504 (eol), 0x0B0A0908, 0x0F0E0D0C (eol+eof).
  - frame_cnt 0→1 on the edge accepting pixel 15.
- m_ready=0 held while streaming:
  - ready_s drops when k=3 and the word is pending; exactly 7 pixels accepted before the stall.
  - m_data stable throughout.
  - On release, no pixel lost or duplicated (compare against a scoreboard).
- Random valid_s (50%) and random m_ready (50%), 3 frames of 8x2:
  - output words equal the packed input sequence.
  - eof count = 3; frame_cnt=3.
- rst asserted after 6 pixels of a frame → m_valid=0 next cycle, frame_cnt=0; the next 4 pixels produce a word with m_sof=1.
- FRAME_CNT_W=2, run 5 frames → frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sobel_out_packer.sv
// sobel_out_packer
// Receive-side endpoint for the 8-bit Sobel edge-map stream. Accepts pixels
// under valid/ready, tracks the raster position inside the frame, packs four
// pixels into a 32-bit word (pixel 0 in the low byte) and presents the word
// downstream with start-of-frame, end-of-line and end-of-frame markers.
// IMAGE_WIDTH must be a multiple of 4 so that words never straddle a line.
module sobel_out_packer #(
    parameter int IMAGE_WIDTH  = 1920,
    parameter int IMAGE_HEIGHT = 1080,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_s,
    output logic                   ready_s,
    input  logic [7:0]             data_s_sobel,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int X_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int Y_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMAGE_HEIGHT - 1);

    logic [1:0]     lane;
    logic [7:0]     lane0;
    logic [7:0]     lane1;
    logic [7:0]     lane2;
    logic           word_sof;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           accept;
    logic           load;
    logic           last_x;
    logic           last_y;

    // Only the word-completing lane can stall, and only while the output slot is full and not draining.
    always_comb begin
        ready_s = !((lane == 2'd3) && m_valid && !m_ready);
    end

    // Handshake and raster-boundary decodes shared by the registers below.
    always_comb begin
        accept = valid_s && ready_s;
        load   = accept && (lane == 2'd3);
        last_x = (x == X_LAST);
        last_y = (y == Y_LAST);
    end

    // Pack register: store lanes 0..2 and remember whether the word began at the frame origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane     <= 2'd0;
            lane0    <= 8'd0;
            lane1    <= 8'd0;
            lane2    <= 8'd0;
            word_sof <= 1'b0;
        end else if (accept) begin
            case (lane)
                2'd0: begin
                    lane0    <= data_s_sobel;
                    word_sof <= (x == '0) && (y == '0);
                end
                2'd1: lane1 <= data_s_sobel;
                2'd2: lane2 <= data_s_sobel;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end

    // Raster counters advance once per accepted pixel; frame_cnt ticks on the frame's final pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (accept) begin
            if (last_x) begin
                x <= '0;
                if (last_y) begin
                    y         <= '0;
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                end else begin
                    y <= y + Y_W'(1);
                end
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    // Single-entry output register: a load wins over a drain, otherwise contents hold until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= 32'd0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= {data_s_sobel, lane2, lane1, lane0};
            m_sof   <= word_sof;
            m_eol   <= last_x;
            m_eof   <= last_x && last_y;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
